// File: rtl/product_bcd_display_pkg.sv
// Shared types and constants for the product BCD display: FSM states,
// conversion length and the active-low 7-segment glyphs.
package product_bcd_display_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // {tens, ones, bin}: two BCD nibbles over the 6-bit binary product.
    localparam int unsigned ShiftW = 14;
    localparam logic [2:0] ConvIters = 3'd6;

    // Bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] Seg0     = 7'h40;
    localparam logic [6:0] Seg1     = 7'h79;
    localparam logic [6:0] Seg2     = 7'h24;
    localparam logic [6:0] Seg3     = 7'h30;
    localparam logic [6:0] Seg4     = 7'h19;
    localparam logic [6:0] Seg5     = 7'h12;
    localparam logic [6:0] Seg6     = 7'h02;
    localparam logic [6:0] Seg7     = 7'h78;
    localparam logic [6:0] Seg8     = 7'h00;
    localparam logic [6:0] Seg9     = 7'h10;
    localparam logic [6:0] SegBlank = 7'h7F;

endpackage

// File: rtl/product_bcd_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes blank.
module bcd_to_7seg
    import product_bcd_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegBlank;
        unique case (bcd_i)
            4'd0:    seg_o = Seg0;
            4'd1:    seg_o = Seg1;
            4'd2:    seg_o = Seg2;
            4'd3:    seg_o = Seg3;
            4'd4:    seg_o = Seg4;
            4'd5:    seg_o = Seg5;
            4'd6:    seg_o = Seg6;
            4'd7:    seg_o = Seg7;
            4'd8:    seg_o = Seg8;
            4'd9:    seg_o = Seg9;
            default: seg_o = SegBlank;
        endcase
    end

endmodule

// File: rtl/product_bcd_display.sv
// Strobed 6-bit product -> two BCD digits via sequential double-dabble, shown on a
// 4-digit multiplexed active-low 7-segment display with leading-zero blanking.
module product_bcd_display
    import product_bcd_display_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] p,
    input  logic       p_valid,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an
);

    state_e                  state_q, state_d;
    logic [ShiftW-1:0]       sh_q, sh_d, adj;
    logic [2:0]              cnt_q, cnt_d;
    logic [3:0]              tens_q, tens_d, ones_q, ones_d;
    logic                    vld_q, vld_d;
    logic                    done_q, done_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic [6:0]              digit_seg;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        adj     = sh_q;
        unique case (state_q)
            StIdle: begin
                if (p_valid) begin
                    sh_d    = {8'd0, p};
                    cnt_d   = ConvIters;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
                if (adj[9:6] >= 4'd5)   adj[9:6]   = adj[9:6] + 4'd3;
                sh_d  = adj << 1;
                cnt_d = cnt_q - 3'd1;
                // Last shift: the nibbles are final on this edge.
                if (cnt_q == 3'd1) begin
                    tens_d  = sh_d[13:10];
                    ones_d  = sh_d[9:6];
                    vld_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sel       = refresh_q[REFRESH_BITS-1 -: 2];
    assign digit     = (sel == 2'd1) ? tens_q : ones_q;
    assign refresh_d = refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    bcd_to_7seg u_bcd_to_7seg (
        .bcd_i (digit),
        .seg_o (digit_seg)
    );

    always_comb begin
        an_d  = 4'b1111;
        seg_d = SegBlank;
        if (vld_q) begin
            unique case (sel)
                2'd0: begin
                    an_d  = 4'b1110;
                    seg_d = digit_seg;
                end
                2'd1: begin
                    if (tens_q != 4'd0) begin
                        an_d  = 4'b1101;
                        seg_d = digit_seg;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            cnt_q     <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            refresh_q <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SegBlank;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            refresh_q <= refresh_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = done_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Self-checking bench for product_bcd_display: behavioural model compared every
// cycle, plus directed conversions with hand-computed digits and glyphs.
module tb_product_bcd_display;

    localparam int unsigned RB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] p = 6'd0;
    logic       p_valid = 1'b0;
    logic       busy, done;
    logic [6:0] seg;
    logic [3:0] an;

    int vectors = 0;
    int errors  = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model state
    bit         m_busy, m_done, m_vld;
    int         m_cnt, m_val, m_tens, m_ones, m_ref;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    product_bcd_display #(.REFRESH_BITS(RB)) dut (
        .clk     (clk),
        .rst     (rst),
        .p       (p),
        .p_valid (p_valid),
        .busy    (busy),
        .done    (done),
        .seg     (seg),
        .an      (an)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: conversion takes 6 cycles after capture; display output lags sel by one edge.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_done = 0; m_vld = 0; m_cnt = 0; m_val = 0;
            m_tens = 0; m_ones = 0; m_ref = 0; m_an = 4'hF; m_seg = 7'h7F;
        end else begin
            int sel;
            sel   = m_ref / (1 << (RB - 2));
            m_an  = 4'hF;
            m_seg = 7'h7F;
            if (m_vld && sel == 0) begin
                m_an = 4'b1110; m_seg = seg_tbl[m_ones];
            end else if (m_vld && sel == 1 && m_tens != 0) begin
                m_an = 4'b1101; m_seg = seg_tbl[m_tens];
            end
            m_done = 0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 6) begin
                    m_busy = 0; m_done = 1; m_vld = 1;
                    m_tens = m_val / 10;
                    m_ones = m_val % 10;
                end
            end else if (p_valid) begin
                m_busy = 1; m_val = int'(p); m_cnt = 0;
            end
            m_ref = (m_ref + 1) % (1 << RB);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_an", an, m_an);
        if (m_an != 4'hF) chk("cyc_seg", seg, m_seg);
    end

    task automatic run_conv(input int v, input int et, input int eo);
        p = 6'(v);
        p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        chk("conv_busy_e0", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("conv_done_pulse", done, (i == 6));
            chk("conv_busy_span", busy, (i < 6));
        end
        chk("model_tens", m_tens, et);
        chk("model_ones", m_ones, eo);
    endtask

    task automatic scan(input logic [6:0] so, input logic [6:0] st, input bit blank);
        int n_one = 0, n_ten = 0, n_bad = 0;
        for (int i = 0; i < 2 * (1 << RB); i++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin n_one++; chk("scan_ones_seg", seg, so); end
                4'b1101: begin n_ten++; if (!blank) chk("scan_tens_seg", seg, st); end
                4'b1111: ;
                default: n_bad++;
            endcase
        end
        chk("scan_ones_slots", n_one, 8);
        chk("scan_tens_slots", n_ten, blank ? 0 : 8);
        chk("scan_bad_an", n_bad, 0);
    endtask

    initial begin
        int n_lit, n_done;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        rst = 1'b0;

        n_lit = 0;
        for (int i = 0; i < 4 * (1 << RB); i++) begin
            @(negedge clk);
            if (an != 4'hF) n_lit++;
        end
        chk("idle_dark", n_lit, 0);

        run_conv(49, 4, 9);
        scan(7'h10, 7'h19, 1'b0);
        run_conv(0, 0, 0);
        scan(7'h40, 7'h7F, 1'b1);
        run_conv(63, 6, 3);
        scan(7'h30, 7'h02, 1'b0);

        // 35 during busy is dropped; 35 coincident with done is taken.
        p = 6'd12; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        repeat (2) @(negedge clk);
        p = 6'd35; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        chk("ign_busy_e3", busy, 1);
        repeat (3) @(negedge clk);
        chk("ign_done_e6", done, 1);
        chk("ign_tens", m_tens, 1);
        chk("ign_ones", m_ones, 2);
        p = 6'd35; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        chk("b2b_busy_e7", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("b2b_done_e13", done, (i == 6));
        end
        chk("b2b_tens", m_tens, 3);
        chk("b2b_ones", m_ones, 5);
        scan(7'h12, 7'h30, 1'b0);

        // Asynchronous reset in the middle of converting 42.
        p = 6'd42; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        n_lit = 0;
        n_done = 0;
        for (int i = 0; i < 2 * (1 << RB); i++) begin
            @(negedge clk);
            if (an != 4'hF) n_lit++;
            if (done) n_done++;
        end
        chk("arst_dark", n_lit, 0);
        chk("arst_no_done", n_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
